// File: rtl/radix2_seq_divider.sv
// Radix-2 restoring sequential divider.
// It produces one quotient bit per clock. Signed division runs on operand
// magnitudes, and a sign correction is applied in a final fix-up cycle.
// The handshake is start/busy/done. Results are held until the next done.
module radix2_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  // Two's-complement negation of a WIDTH-bit value
  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Magnitude of v when it is a negative signed operand; otherwise v is returned unchanged.
  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which is still exact as an unsigned value.
  function automatic logic [WIDTH-1:0] mag_val(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? neg_val(v) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;

  // One restoring step. Shift the partial remainder left and trial-subtract the divisor magnitude.
  always_comb begin
    shifted_s = {rem_q, quo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, dvs_q};
  end

  // Next-state logic for the FSM, the datapath registers and the output registers
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_pend_d   = dz_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          busy_d    = 1'b1;
          cnt_d     = {CW{1'b0}};
          dvs_d     = mag_val(divisor, signed_op);
          if (divisor == ZERO_W) begin
            // Divide by zero: the fixed results pass through FIX without correction
            rem_d     = dividend;
            quo_d     = ONES_W;
            qneg_d    = 1'b0;
            rneg_d    = 1'b0;
            dz_pend_d = 1'b1;
            state_d   = ST_FIX;
          end else begin
            rem_d     = ZERO_W;
            quo_d     = mag_val(dividend, signed_op);
            qneg_d    = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d    = signed_op & dividend[WIDTH-1];
            dz_pend_d = 1'b0;
            state_d   = ST_ITER;
          end
        end else if (done_q) begin
          // busy stays high through the done cycle and drops on the following edge
          busy_d = 1'b0;
        end else begin
          busy_d = busy_q;
        end
      end
      ST_ITER: begin
        if (!diff_s[WIDTH]) begin
          rem_d = diff_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_s[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_FIX: begin
        quotient_d  = qneg_q ? neg_val(quo_q) : quo_q;
        remainder_d = rneg_q ? neg_val(rem_q) : rem_q;
        dbz_d       = dz_pend_q;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so that a reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= ZERO_W;
      quo_q       <= ZERO_W;
      dvs_q       <= ZERO_W;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_pend_q   <= 1'b0;
      quotient_q  <= ZERO_W;
      remainder_q <= ZERO_W;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_pend_q   <= dz_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_radix2_seq_divider.sv
// Directed and random checks for radix2_seq_divider (WIDTH=32)
module tb_radix2_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_errors;

  radix2_seq_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one division, wait for done (bounded), and return the results and the latency in cycles
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output int lat);
    @(negedge clk);
    start     = 1'b1;
    signed_op = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    check_val("busy_after_accept", 32'(busy), 32'd1);
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 100) check_val("done_timeout", 32'(lat), 32'd0);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    check_val("busy_at_done", 32'(busy), 32'd1);
    @(negedge clk);
    check_val("done_one_pulse", 32'(done), 32'd0);
    check_val("busy_after_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] q, r;
    logic        dz;
    int          lat;
    int          err_before;
    int          rnd_ok;
    int          rnd_bad;
    int          n_done;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;

    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_q", quotient, 32'd0);
    check_val("rst_r", remainder, 32'd0);
    check_val("rst_dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: sign, dividend, divisor, Q, R, dz, latency
    vecs.push_back('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33});
    vecs.push_back('{1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 33});
    vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{1'b0, 32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345, 1'b1, 1});
    vecs.push_back('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33});
    vecs.push_back('{1'b0, 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 33});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 33});
    vecs.push_back('{1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1});

    foreach (vecs[i]) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dz, lat);
      check_val($sformatf("v%0d_q", i), q, vecs[i].q);
      check_val($sformatf("v%0d_r", i), r, vecs[i].r);
      check_val($sformatf("v%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      check_val($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // A start pulse at accept+5 carrying other operands must be ignored
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 4) begin
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    check_val("ign_lat", 32'(lat), 32'd33);
    check_val("ign_q", quotient, 32'd14);
    check_val("ign_r", remainder, 32'd2);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("ign_not_queued", 32'(busy), 32'd0);

    // Make the held outputs non-zero with dz set before the abort
    run_div(1'b0, 32'd12345, 32'd0, q, r, dz, lat);
    check_val("pre_rst_dz", 32'(dz), 32'd1);

    // Reset at accept+10 aborts the operation and clears every output
    @(negedge clk);
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 32'd200;
    divisor   = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_q", quotient, 32'd0);
    check_val("abort_r", remainder, 32'd0);
    check_val("abort_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("abort_no_done", 32'(n_done), 32'd0);
    check_val("abort_idle", 32'(busy), 32'd0);

    // Random signed and unsigned pairs against the language operators
    rnd_ok  = 0;
    rnd_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      logic        sgn;
      logic [31:0] a, b, eq, er;
      int          sq, sr;
      sgn = i[0];
      a   = (i % 5 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      b   = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i % 7 == 0) b = ~b + 32'd1;
      if (b == 32'd0) b = 32'd1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      if (sgn) begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        eq = 32'(sq);
        er = 32'(sr);
      end else begin
        eq = a / b;
        er = a % b;
      end
      err_before = n_errors;
      run_div(sgn, a, b, q, r, dz, lat);
      check_val($sformatf("rnd%0d_q a=%08h b=%08h s=%0d", i, a, b, sgn), q, eq);
      check_val($sformatf("rnd%0d_r", i), r, er);
      if (n_errors == err_before) rnd_ok++;
      else rnd_bad++;
    end
    $display("Random division: %0d correct, %0d wrong", rnd_ok, rnd_bad);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
